// File: rtl/grid_link_hub_pkg.sv
// Shared types and helpers for the grid link hub.
// Tag field layout and the broadcast destination code.
package grid_link_hub_pkg;

  localparam int TAG_WIDTH = 4;
  localparam int MAX_DATA_WIDTH = 1024;

  typedef logic [TAG_WIDTH-1:0] tag_t;

  localparam tag_t BROADCAST_TAG = 4'hF;

  function automatic tag_t tag_of(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input int unsigned               msb
  );
    return data[msb -: TAG_WIDTH];
  endfunction

endpackage

// File: rtl/grid_link_fifo.sv
// Per-link inbound FIFO with a registered not-full ready.
// Pointers carry one extra wrap bit to tell full from empty.
import grid_link_hub_pkg::*;

module grid_link_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  not_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;
  logic [PW-1:0] cnt_n;
  logic          wr_en;
  logic          rd_go;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  assign wr_en     = wr_valid && wr_ready;
  assign not_empty = wr_ptr != rd_ptr;
  assign rd_go     = rd_en && not_empty;
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  assign wr_ptr_n = wr_ptr + PW'(wr_en);
  assign rd_ptr_n = rd_ptr + PW'(rd_go);
  assign cnt_n    = wr_ptr_n - rd_ptr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_ready <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      wr_ready <= cnt_n != PW'(FIFO_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/grid_link_hub.sv
// Merges NUM_LINKS inbound grid links into one controller stream
// and routes controller messages out by destination tag.
import grid_link_hub_pkg::*;

module grid_link_hub #(
  parameter int NUM_LINKS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_MSB    = 63
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LINKS*DATA_WIDTH-1:0] link_in_data,
  input  logic [NUM_LINKS-1:0]            link_in_valid,
  output logic [NUM_LINKS-1:0]            link_in_ready,
  output logic [NUM_LINKS*DATA_WIDTH-1:0] link_out_data,
  output logic [NUM_LINKS-1:0]            link_out_valid,
  input  logic [NUM_LINKS-1:0]            link_out_ready,
  output logic [DATA_WIDTH-1:0]           ctrl_rx_data,
  output logic                            ctrl_rx_valid,
  input  logic                            ctrl_rx_ready,
  input  logic [DATA_WIDTH-1:0]           ctrl_tx_data,
  input  logic                            ctrl_tx_valid,
  output logic                            ctrl_tx_ready,
  output logic                            bad_dest,
  output logic                            hub_busy
);

  localparam int NL = NUM_LINKS;
  localparam int DW = DATA_WIDTH;

  logic [NL-1:0] fifo_ne;
  logic [NL-1:0] fifo_rd;
  logic [DW-1:0] fifo_dout [NL];

  for (genvar gi = 0; gi < NL; gi++) begin : g_fifo
    grid_link_fifo #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (link_in_valid[gi]),
      .wr_data   (link_in_data[gi*DW +: DW]),
      .wr_ready  (link_in_ready[gi]),
      .rd_en     (fifo_rd[gi]),
      .rd_data   (fifo_dout[gi]),
      .not_empty (fifo_ne[gi])
    );
  end

  tag_t          rr_ptr;
  tag_t          winner;
  tag_t          rr_next;
  logic          found;
  logic          rx_load;
  logic [DW-1:0] rx_d;

  // Search starts at rr_ptr and wraps, so the first hit is the RR winner.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NL; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NL) idx = idx - NL;
      for (int i = 0; i < NL; i++) begin
        if (!found && fifo_ne[i] && i == idx) begin
          found  = 1'b1;
          winner = tag_t'(i);
        end
      end
    end
  end

  assign rx_load = found && (!ctrl_rx_valid || ctrl_rx_ready);

  assign rr_next = (int'(winner) == NL - 1) ? '0 : winner + 1'b1;

  always_comb begin
    fifo_rd = '0;
    rx_d    = '0;
    for (int i = 0; i < NL; i++) begin
      if (winner == tag_t'(i)) begin
        rx_d       = fifo_dout[i];
        fifo_rd[i] = rx_load;
      end
    end
    rx_d[TAG_MSB -: TAG_WIDTH] = winner;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_rx_valid <= 1'b0;
      ctrl_rx_data  <= '0;
      rr_ptr        <= '0;
    end else if (rx_load) begin
      ctrl_rx_valid <= 1'b1;
      ctrl_rx_data  <= rx_d;
      rr_ptr        <= rr_next;
    end else if (ctrl_rx_ready) begin
      ctrl_rx_valid <= 1'b0;
    end
  end

  tag_t          dest;
  logic          is_bcast;
  logic          is_uni;
  logic          uni_free;
  logic          tx_fire;
  logic          drop;
  logic [NL-1:0] free;
  logic [NL-1:0] out_load;

  assign dest     = tag_of(MAX_DATA_WIDTH'(ctrl_tx_data), TAG_MSB);
  assign is_bcast = dest == BROADCAST_TAG;
  assign is_uni   = !is_bcast && (int'(dest) < NL);
  assign free     = ~link_out_valid | link_out_ready;
  assign tx_fire  = ctrl_tx_valid && ctrl_tx_ready;
  assign drop     = ctrl_tx_valid && !is_bcast && !is_uni;

  always_comb begin
    uni_free = 1'b0;
    out_load = '0;
    for (int i = 0; i < NL; i++) begin
      if (dest == tag_t'(i)) uni_free = free[i];
      out_load[i] = tx_fire &&
        (is_bcast || (is_uni && dest == tag_t'(i)));
    end
  end

  // Unknown destinations are swallowed so the controller never stalls.
  always_comb begin
    ctrl_tx_ready = 1'b1;
    unique case (1'b1)
      is_bcast: ctrl_tx_ready = &free;
      is_uni:   ctrl_tx_ready = uni_free;
      default:  ctrl_tx_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      link_out_valid <= '0;
      link_out_data  <= '0;
      bad_dest       <= 1'b0;
      hub_busy       <= 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (out_load[i]) begin
          link_out_valid[i]        <= 1'b1;
          link_out_data[i*DW +: DW] <= ctrl_tx_data;
        end else if (link_out_ready[i]) begin
          link_out_valid[i] <= 1'b0;
        end
      end
      bad_dest <= drop;
      hub_busy <= (|fifo_ne) || (|link_out_valid) ||
                  ctrl_rx_valid || ctrl_tx_valid;
    end
  end

endmodule

// File: doc/grid_link_hub.md
Name: grid_link_hub

Overview:
- Parametrised successor to the fixed two-port grid link wiring of the single-FPGA core.
- Connects the unified controller's single grid message stream to NUM_LINKS neighbour-FPGA grid links.
- Inbound: per-link FIFO buffering, then round-robin arbitration into one stream, with the source link tagged in each message.
- Outbound: routes controller messages by destination field to one link, or broadcasts to all; reports busy for router-idle detection.

Parameters:
- NUM_LINKS, 2, number of grid links (1..15).
- DATA_WIDTH, 64, message width (>= 8).
- FIFO_DEPTH, 4, per-link inbound FIFO depth (power of 2, >= 2).
- TAG_MSB, 63, top bit of the 4-bit link tag/destination field [TAG_MSB:TAG_MSB-3].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- link_in_data  in  NUM_LINKS*DATA_WIDTH  inbound beats; link i at [i*DATA_WIDTH +: DATA_WIDTH]
- link_in_valid  in  NUM_LINKS  inbound valid
- link_in_ready  out  NUM_LINKS  inbound ready (FIFO not full)
- link_out_data  out  NUM_LINKS*DATA_WIDTH  outbound beats
- link_out_valid  out  NUM_LINKS  outbound valid
- link_out_ready  in  NUM_LINKS  outbound ready
- ctrl_rx_data  out  DATA_WIDTH  merged inbound to controller
- ctrl_rx_valid  out  1
- ctrl_rx_ready  in  1
- ctrl_tx_data  in  DATA_WIDTH  controller outbound
- ctrl_tx_valid  in  1
- ctrl_tx_ready  out  1
- bad_dest  out  1  one-cycle pulse when a message is dropped
- hub_busy  out  1  any FIFO, output register, or ctrl_rx register occupied

Behaviour:
- Clock and reset: one clock clk. reset is synchronous and active-high.
- Handshake: a transfer occurs when valid && ready on the rising edge. Valid never depends on ready. Data is held stable while valid && !ready.
- Reset values:
  - link_in_ready = all 1s.
  - link_out_valid = 0, ctrl_rx_valid = 0, bad_dest = 0, hub_busy = 0.
  - Data outputs = 0.
  - All FIFO pointers cleared; RR pointer = 0.
  - Reset mid-operation discards all buffered messages with no partial output.
- Inbound FIFO (per link):
  - Write when link_in_valid[i] && link_in_ready[i].
  - link_in_ready[i] = !full, registered from the pointers.
  - Simultaneous read and write when full is not permitted; ready is already low.
  - Simultaneous read and write when non-empty keeps the count unchanged.
  - Pointer width is log2(FIFO_DEPTH)+1, wrapping naturally.
- Inbound arbiter:
  - Single-entry ctrl_rx output register, loaded when empty or when it is being consumed this cycle.
  - Winner is the lowest index >= rr_ptr among non-empty FIFOs, wrapping around.
  - On load, rr_ptr = winner+1 mod NUM_LINKS.
  - Loaded data has the tag field overwritten with the winner index.
  - Latency: an idle beat accepted on a link at edge N gives ctrl_rx_valid high after edge N+1. Sustained throughput is 1 beat/cycle.
- Outbound:
  - dest = ctrl_tx_data tag field.
  - Each link has a single-entry output register: free = !link_out_valid[i] || link_out_ready[i].
  - Unicast, dest < NUM_LINKS: ctrl_tx_ready = free[dest]. Register loaded next edge, data unmodified.
  - Broadcast, dest = 4'hF: ctrl_tx_ready = AND of all free. All registers are loaded in the same cycle, all-or-nothing.
  - Other dest: ctrl_tx_ready = 1, beat dropped, bad_dest pulses the cycle after acceptance.
  - Outbound latency: 1 cycle.
- hub_busy: registered OR of FIFO non-empty, any link_out_valid, ctrl_rx_valid, and ctrl_tx_valid.

Decomposition:
- Shared package:
  - TAG_WIDTH = 4
  - BROADCAST_TAG = 4'hF
  - function tag_of(data)
- Sub-module grid_link_fifo (DATA_WIDTH, FIFO_DEPTH), instantiated NUM_LINKS times via generate.
- Arbiter and outbound router stay inline.

Test Plan:
- Reset hold 3 cycles, then release -> link_in_ready = 2'b11, all valids 0, hub_busy 0.
- Single beat on link 1 (64'h0000_0000_0000_00AA) -> ctrl_rx_data = 64'h1000_0000_0000_00AA, ctrl_rx_valid high 2 edges after the beat.
- Both links continuously valid, ctrl_rx_ready = 1 for 8 cycles -> grants strictly alternate 0,1,0,1; FIFOs never overflow.
- ctrl_rx_ready = 0 with 5 beats on link 0, FIFO_DEPTH = 4:
  - 1 beat goes to the output register and 4 to the FIFO, then link_in_ready[0] = 0.
  - After release, the 5 beats are delivered in order.
- ctrl_tx with tag 4'hF while link_out_ready = 2'b01 -> ctrl_tx_ready = 0 until link 1 is free; both link_out_valid then rise on the same cycle.
- ctrl_tx with tag 4'h5, NUM_LINKS = 2 -> accepted immediately, no link_out_valid, bad_dest pulses for exactly 1 cycle.
